// File: rtl/trigger_capture.sv
// trigger_capture
//   Decimates the ADC sample stream, waits for an edge trigger (or an auto
//   timeout), captures DEPTH consecutive samples into a shadow buffer and
//   publishes that buffer to data_display at the start of vertical blanking,
//   so the drawing stage never sees a half-updated waveform.
//
// Ports
//   clk            system pixel clock
//   rst            asynchronous, active-high reset
//   adc_data       unsigned ADC sample
//   adc_valid      adc_data valid this cycle
//   trigger_level  trigger threshold
//   trig_falling   0 = rising-edge trigger, 1 = falling-edge trigger
//   auto_mode      1 = allow a timeout-forced capture
//   decim          keep one of every (decim+1) valid samples
//   vblnk          vertical blank from the timing chain
//   data_display   published waveform (DEPTH entries)
//   frame_ready    one-cycle pulse in the cycle new data_display is visible
//   triggered      last publish came from a real trigger (0 = auto)
module trigger_capture #(
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 256,
    parameter int AUTO_TIMEOUT = 65535,
    parameter int MIDSCALE     = 2047
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] trigger_level,
    input  logic              trig_falling,
    input  logic              auto_mode,
    input  logic [3:0]        decim,
    input  logic              vblnk,
    output logic [DATA_W-1:0] data_display [0:DEPTH-1],
    output logic              frame_ready,
    output logic              triggered
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TO_W  = $clog2(AUTO_TIMEOUT);

    typedef enum logic [1:0] {
        S_ARM,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [3:0]        dec_cnt;
    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic [TO_W-1:0]   to_cnt;
    logic [IDX_W-1:0]  idx;
    logic              trig_flag;
    logic              vblnk_d;

    logic              accept;
    logic              rise_hit;
    logic              fall_hit;
    logic              trig_hit;
    logic              timeout_hit;
    logic              vblnk_rise;
    logic              start_cap;
    logic              publish;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;

    logic [DATA_W-1:0] shadow [0:DEPTH-1];

    // Sample qualification and trigger detection
    always_comb begin
        accept      = adc_valid && (dec_cnt == decim);
        rise_hit    = (prev < trigger_level) && (adc_data >= trigger_level);
        fall_hit    = (prev > trigger_level) && (adc_data <= trigger_level);
        trig_hit    = accept && prev_valid && (trig_falling ? fall_hit : rise_hit);
        // Trigger has priority: timeout only counts when no trigger fired.
        timeout_hit = accept && !trig_hit && auto_mode &&
                      (to_cnt == TO_W'(AUTO_TIMEOUT - 1));
        vblnk_rise  = vblnk && !vblnk_d;
        start_cap   = (state == S_WAIT) && (trig_hit || timeout_hit);
        wr_en       = start_cap || ((state == S_CAPTURE) && accept);
        wr_addr     = start_cap ? '0 : idx;
    end

    // Next-state and publish decode
    always_comb begin
        next_state = state;
        publish    = 1'b0;
        case (state)
            S_ARM: begin
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (start_cap) begin
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (accept && (idx == IDX_W'(DEPTH - 1))) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (vblnk_rise) begin
                    publish    = 1'b1;
                    next_state = S_ARM;
                end
            end
            default: begin
                next_state = S_ARM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ARM;
        end else begin
            state <= next_state;
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt     <= '0;
            prev_valid  <= 1'b0;
            to_cnt      <= '0;
            idx         <= '0;
            trig_flag   <= 1'b0;
            vblnk_d     <= 1'b0;
            frame_ready <= 1'b0;
            triggered   <= 1'b0;
        end else begin
            vblnk_d     <= vblnk;
            frame_ready <= publish;

            if (adc_valid) begin
                dec_cnt <= accept ? 4'd0 : dec_cnt + 4'd1;
            end

            // Arming forgets the previous sample so a stale value from an
            // earlier capture can never fabricate an edge.
            if (state == S_ARM) begin
                prev_valid <= 1'b0;
                to_cnt     <= '0;
            end else if ((state == S_WAIT) && accept) begin
                prev_valid <= 1'b1;
                if (!start_cap && auto_mode) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end

            if (start_cap) begin
                idx       <= IDX_W'(1);
                trig_flag <= trig_hit;
            end else if ((state == S_CAPTURE) && accept) begin
                idx <= idx + IDX_W'(1);
            end

            if (publish) begin
                triggered <= trig_flag;
            end
        end
    end

    // Datapath registers (no reset: contents are qualified by the FSM)
    always_ff @(posedge clk) begin
        if ((state == S_WAIT) && accept) begin
            prev <= adc_data;
        end
        if (wr_en) begin
            shadow[wr_addr] <= adc_data;
        end
    end

    // Published waveform: whole buffer copied in one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_display[i] <= DATA_W'(MIDSCALE);
            end
        end else if (publish) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_display[i] <= shadow[i];
            end
        end
    end

endmodule
